// File: rtl/fm_op_sequencer_if.sv
// Control and datapath-facing signals of the FM operator sequencer.
// The master side is the sequencer; the slave side is the timebase/register file/operator pipeline.
interface fm_op_sequencer_if;
    logic       sample_tick;
    logic       keyon_wr;
    logic [5:0] keyon_op;
    logic       overrun_clr;
    logic [5:0] op_sel;
    logic       next;
    logic       restart;
    logic [2:0] vib_pos;
    logic       busy;
    logic       frame_done;
    logic       overrun;

    modport master (
        input  sample_tick,
        input  keyon_wr,
        input  keyon_op,
        input  overrun_clr,
        output op_sel,
        output next,
        output restart,
        output vib_pos,
        output busy,
        output frame_done,
        output overrun
    );

    modport slave (
        output sample_tick,
        output keyon_wr,
        output keyon_op,
        output overrun_clr,
        input  op_sel,
        input  next,
        input  restart,
        input  vib_pos,
        input  busy,
        input  frame_done,
        input  overrun
    );
endinterface

// File: rtl/fm_op_sequencer.sv
// Sweeps the shared FM phase datapath over every operator once per sample frame,
// turning queued key-ons into per-operator restarts and stepping the vibrato position.
module fm_op_sequencer #(
    parameter int NUM_OPS = 36,
    parameter int SETTLE  = 2,
    parameter int VIB_DIV = 1024
) (
    input logic               clk,
    input logic               reset,
    fm_op_sequencer_if.master bus
);
    localparam int DIV_W = $clog2(VIB_DIV);
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [5:0]       LAST_OP    = 6'(NUM_OPS - 1);
    localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE - 1);
    localparam logic [DIV_W-1:0] DIV_END    = DIV_W'(VIB_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_STEP,
        ST_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] settle_cnt;
    logic [DIV_W-1:0] frame_div;
    logic [63:0]      pending;
    logic [63:0]      pending_next;
    logic             keyon_ok;

    assign keyon_ok = bus.keyon_wr && ({1'b0, bus.keyon_op} < 7'(NUM_OPS));

    // A key-on landing on the operator being stepped is applied after the clear, so it survives to the next frame.
    always_comb begin
        pending_next = pending;
        if (state == ST_STEP) begin
            pending_next[bus.op_sel] = 1'b0;
        end
        if (keyon_ok) begin
            pending_next[bus.keyon_op] = 1'b1;
        end
    end

    // Outputs are registered one cycle ahead of the state they belong to, so restart
    // samples the pending vector as it will stand during the STEP cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            settle_cnt     <= '0;
            frame_div      <= '0;
            pending        <= '0;
            bus.op_sel     <= '0;
            bus.next       <= 1'b0;
            bus.restart    <= 1'b0;
            bus.vib_pos    <= '0;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            pending        <= pending_next;
            bus.next       <= 1'b0;
            bus.restart    <= 1'b0;
            bus.frame_done <= 1'b0;

            if (bus.sample_tick && (state != ST_IDLE)) begin
                bus.overrun <= 1'b1;
            end else if (bus.overrun_clr) begin
                bus.overrun <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.sample_tick) begin
                        state      <= ST_SETTLE;
                        bus.op_sel <= '0;
                        settle_cnt <= '0;
                        bus.busy   <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_END) begin
                        state       <= ST_STEP;
                        bus.next    <= 1'b1;
                        bus.restart <= pending_next[bus.op_sel];
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_STEP: begin
                    if (bus.op_sel == LAST_OP) begin
                        // Frame bookkeeping becomes visible during the DONE cycle itself.
                        state          <= ST_DONE;
                        bus.frame_done <= 1'b1;
                        bus.op_sel     <= '0;
                        frame_div      <= frame_div + 1'b1;
                        if (frame_div == DIV_END) begin
                            bus.vib_pos <= bus.vib_pos + 3'd1;
                        end
                    end else begin
                        state      <= ST_SETTLE;
                        bus.op_sel <= bus.op_sel + 6'd1;
                        settle_cnt <= '0;
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fm_op_sequencer.sv
// Self-checking bench for fm_op_sequencer: directed scenarios plus random traffic,
// compared every cycle against a frame-timeline model of the sequencer.
module tb_fm_op_sequencer;
    localparam int NUM_OPS   = 36;
    localparam int SETTLE    = 2;
    // Short divider so the vibrato position wraps within a few dozen frames.
    localparam int VIB_DIV   = 4;
    localparam int PERIOD    = SETTLE + 1;
    localparam int LAST_OFF  = NUM_OPS * PERIOD + 1;
    localparam int FRAME_LEN = LAST_OFF + 1;

    logic clk;
    logic reset;
    fm_op_sequencer_if bus ();

    fm_op_sequencer #(
        .NUM_OPS (NUM_OPS),
        .SETTLE  (SETTLE),
        .VIB_DIV (VIB_DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    int          cyc        = 0;
    int          frame_start = -1;
    int          completed  = 0;
    logic        model_ovr  = 1'b0;
    logic [63:0] model_pend = '0;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed != expected) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, want %0d", tag, cyc, observed, expected);
        end
    endtask

    // One clock cycle: check what the DUT shows now, then drive this cycle's inputs and advance the model.
    task automatic applyStimulus(input logic tick, input logic kw, input logic [5:0] kop,
                                 input logic clr, input logic rst);
        int   off;
        int   exp_op;
        int   step_op;
        logic exp_next;
        logic exp_rst;
        logic exp_busy;
        logic exp_fd;

        @(negedge clk);
        off      = (frame_start >= 0) ? (cyc - frame_start) : -1;
        exp_op   = 0;
        step_op  = -1;
        exp_next = 1'b0;
        exp_rst  = 1'b0;
        exp_busy = 1'b0;
        exp_fd   = 1'b0;
        if (off >= 1) begin
            exp_busy = 1'b1;
            if (off == LAST_OFF) begin
                exp_fd = 1'b1;
                completed++;
            end else begin
                exp_op = (off - 1) / PERIOD;
                if ((off % PERIOD) == 0) begin
                    exp_next = 1'b1;
                    step_op  = exp_op;
                    exp_rst  = model_pend[step_op];
                end
            end
        end

        checkOutput("op_sel",     bus.op_sel,     exp_op);
        checkOutput("next",       bus.next,       exp_next);
        checkOutput("restart",    bus.restart,    exp_rst);
        checkOutput("busy",       bus.busy,       exp_busy);
        checkOutput("frame_done", bus.frame_done, exp_fd);
        checkOutput("overrun",    bus.overrun,    model_ovr);
        checkOutput("vib_pos",    bus.vib_pos,    (completed / VIB_DIV) % 8);

        bus.sample_tick = tick;
        bus.keyon_wr    = kw;
        bus.keyon_op    = kop;
        bus.overrun_clr = clr;
        reset           = rst;

        if (rst) begin
            model_pend  = '0;
            frame_start = -1;
            completed   = 0;
            model_ovr   = 1'b0;
        end else begin
            if (step_op >= 0) model_pend[step_op] = 1'b0;
            if (kw && (int'(kop) < NUM_OPS)) model_pend[kop] = 1'b1;
            if (tick && (off >= 1)) model_ovr = 1'b1;
            else if (clr) model_ovr = 1'b0;
            if (off == LAST_OFF) frame_start = -1;
            else if (tick && (off < 1)) frame_start = cyc;
        end
        cyc++;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    endtask

    // Full frame with an optional event at a given offset from the tick; ends on the first idle cycle.
    task automatic runFrame(input int at_off, input logic kw, input logic [5:0] kop,
                            input logic tick2, input logic clr);
        applyStimulus(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        idleCycles(at_off - 1);
        applyStimulus(tick2, kw, kop, clr, 1'b0);
        idleCycles(FRAME_LEN - at_off);
    endtask

    initial begin
        reset           = 1'b1;
        bus.sample_tick = 1'b0;
        bus.keyon_wr    = 1'b0;
        bus.keyon_op    = 6'd0;
        bus.overrun_clr = 1'b0;

        applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        idleCycles(3);

        // Plain frame with no key-ons.
        runFrame(10, 1'b0, 6'd0, 1'b0, 1'b0);
        idleCycles(2);

        // Key-on for op 5 and an out-of-range op 40 while idle, then two frames.
        applyStimulus(1'b0, 1'b1, 6'd5, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 6'd40, 1'b0, 1'b0);
        runFrame(10, 1'b0, 6'd0, 1'b0, 1'b0);
        runFrame(10, 1'b0, 6'd0, 1'b0, 1'b0);

        // Key-on for op 7 in the very cycle op 7 is stepped, first not pending, then already pending.
        runFrame(8 * PERIOD, 1'b1, 6'd7, 1'b0, 1'b0);
        runFrame(10, 1'b0, 6'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 6'd7, 1'b0, 1'b0);
        runFrame(8 * PERIOD, 1'b1, 6'd7, 1'b0, 1'b0);
        runFrame(10, 1'b0, 6'd0, 1'b0, 1'b0);

        // Overrun: mid-frame tick, then clear racing a second tick, then clear alone.
        runFrame(50, 1'b0, 6'd0, 1'b1, 1'b0);
        runFrame(50, 1'b0, 6'd0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
        idleCycles(2);

        // Tick landing on the DONE cycle is an overrun, not a new frame.
        runFrame(LAST_OFF, 1'b0, 6'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 6'd0, 1'b1, 1'b0);

        // Vibrato: from reset, run enough frames for vib_pos to wrap 7 -> 0.
        applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
        for (int f = 0; f < 8 * VIB_DIV + 1; f++) runFrame(5, 1'b0, 6'd0, 1'b0, 1'b0);

        // Reset at op_sel 20 with op 30 pending drops the frame and the key-on.
        applyStimulus(1'b0, 1'b1, 6'd30, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        idleCycles(20 * PERIOD);
        applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
        idleCycles(3);
        runFrame(10, 1'b0, 6'd0, 1'b0, 1'b0);

        // Random traffic: ticks at arbitrary times, key-ons to any index, clears and rare resets.
        for (int i = 0; i < 4000; i++) begin
            applyStimulus(($urandom % 90) == 0, ($urandom % 6) == 0, 6'($urandom % 64),
                          ($urandom % 40) == 0, ($urandom % 1500) == 0);
        end
        idleCycles(FRAME_LEN + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
